// File: rtl/ysyx_25040129_arbiter.sv
// Two-master AXI4 arbiter (IFU burst reads, LSU single-beat reads/writes) onto one downstream port.
// Grant is registered one cycle after the request is seen in IDLE, then all channels pass through combinationally with no buffering.
module ysyx_25040129_arbiter #(
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] ifu_araddr,
    input  logic [2:0]  ifu_arsize,
    input  logic [7:0]  ifu_arlen,
    input  logic [1:0]  ifu_arburst,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    output logic        ifu_rlast,
    input  logic        ifu_rready,

    input  logic [31:0] lsu_araddr,
    input  logic [2:0]  lsu_arsize,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,

    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic [7:0]  arlen,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,

    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [1:0]  burst;
    } ar_t;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            bus_timeout_q, bus_timeout_d;

    logic ifu_req, lsu_wreq, lsu_rreq, lsu_req;
    ar_t  ar_dat;

    assign ifu_req  = ifu_arvalid;
    assign lsu_wreq = lsu_awvalid && lsu_wvalid;
    assign lsu_rreq = lsu_arvalid;
    assign lsu_req  = lsu_wreq || lsu_rreq;

    // Grant and completion; on contention the master that did not win last time goes first.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (ifu_req && (!lsu_req || last_grant_q)) begin
                    state_d      = IFU_RD;
                    last_grant_d = 1'b0;
                end else if (lsu_req) begin
                    state_d      = lsu_wreq ? LSU_WR : LSU_RD;
                    last_grant_d = 1'b1;
                end
            end
            IFU_RD: if (rvalid && ifu_rready && rlast) state_d = IDLE;
            LSU_RD: if (rvalid && lsu_rready)          state_d = IDLE;
            LSU_WR: if (bvalid && lsu_bready)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Watchdog only flags; the open transaction is left to finish on its own.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        bus_timeout_d = bus_timeout_q || ((state_q != IDLE) && (to_cnt_d == TO_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            to_cnt_q      <= '0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            to_cnt_q      <= to_cnt_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    assign bus_timeout = bus_timeout_q;
    assign araddr      = ar_dat.addr;
    assign arsize      = ar_dat.size;
    assign arlen       = ar_dat.len;
    assign arburst     = ar_dat.burst;

    // Every output is a pure function of state, so an async reset silences the port instantly.
    always_comb begin
        ar_dat      = '0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        awaddr      = '0;
        awvalid     = 1'b0;
        wdata       = '0;
        wstrb       = '0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rvalid  = 1'b0;
        ifu_rlast   = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = '0;
        lsu_bvalid  = 1'b0;
        case (state_q)
            IFU_RD: begin
                ar_dat      = '{addr: ifu_araddr, size: ifu_arsize, len: ifu_arlen, burst: ifu_arburst};
                arvalid     = ifu_arvalid;
                ifu_arready = arready;
                ifu_rdata   = rdata;
                ifu_rresp   = rresp;
                ifu_rvalid  = rvalid;
                ifu_rlast   = rlast;
                rready      = ifu_rready;
            end
            LSU_RD: begin
                ar_dat      = '{addr: lsu_araddr, size: lsu_arsize, len: 8'd0, burst: 2'b01};
                arvalid     = lsu_arvalid;
                lsu_arready = arready;
                lsu_rdata   = rdata;
                lsu_rresp   = rresp;
                lsu_rvalid  = rvalid;
                rready      = lsu_rready;
            end
            LSU_WR: begin
                awaddr      = lsu_awaddr;
                awvalid     = lsu_awvalid;
                lsu_awready = awready;
                wdata       = lsu_wdata;
                wstrb       = lsu_wstrb;
                wvalid      = lsu_wvalid;
                lsu_wready  = wready;
                lsu_bresp   = bresp;
                lsu_bvalid  = bvalid;
                bready      = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_arbiter.sv
// Bench for ysyx_25040129_arbiter: two upstream master drivers, a downstream memory model
// and an in-order scoreboard of the responses each master should receive.
module tb_ysyx_25040129_arbiter;

    logic        clk, rst_n;
    logic [31:0] ifu_araddr;  logic [2:0] ifu_arsize; logic [7:0] ifu_arlen; logic [1:0] ifu_arburst;
    logic        ifu_arvalid, ifu_arready;
    logic [31:0] ifu_rdata;   logic [1:0] ifu_rresp;  logic ifu_rvalid, ifu_rlast, ifu_rready;
    logic [31:0] lsu_araddr;  logic [2:0] lsu_arsize; logic lsu_arvalid, lsu_arready;
    logic [31:0] lsu_rdata;   logic [1:0] lsu_rresp;  logic lsu_rvalid, lsu_rready;
    logic [31:0] lsu_awaddr;  logic lsu_awvalid, lsu_awready;
    logic [31:0] lsu_wdata;   logic [3:0] lsu_wstrb;  logic lsu_wvalid, lsu_wready;
    logic [1:0]  lsu_bresp;   logic lsu_bvalid, lsu_bready;
    logic [31:0] araddr;      logic [2:0] arsize; logic [7:0] arlen; logic [1:0] arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;       logic [1:0] rresp;  logic rvalid, rlast, rready;
    logic [31:0] awaddr;      logic awvalid, awready;
    logic [31:0] wdata;       logic [3:0] wstrb;  logic wvalid, wready;
    logic [1:0]  bresp;       logic bvalid, bready;
    logic        bus_timeout;

    ysyx_25040129_arbiter #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize), .ifu_arlen(ifu_arlen), .ifu_arburst(ifu_arburst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rlast(ifu_rlast),
        .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .bus_timeout(bus_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: src 0 = IFU R beat, 1 = LSU R beat, 2 = LSU B response.
    typedef struct {
        int          src;
        logic [31:0] dat;
        logic [1:0]  resp;
        logic        last;
    } exp_t;
    exp_t sb[$];

    function automatic void push_ifu(input logic [31:0] a, input logic [7:0] len);
        for (int b = 0; b <= int'(len); b++) sb.push_back('{0, a + 32'(b), 2'b00, (b == int'(len))});
    endfunction
    function automatic void push_lsu_r(input logic [31:0] a);
        sb.push_back('{1, a, 2'b00, 1'b1});
    endfunction
    function automatic void push_lsu_b(input logic [1:0] r);
        sb.push_back('{2, 32'd0, r, 1'b1});
    endfunction

    task automatic sb_pop(input int src, input logic [31:0] dat, input logic [1:0] resp, input logic last);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected", 32'(src), 32'hffff_ffff);
        end else begin
            e = sb.pop_front();
            chk("sb_src", 32'(src), 32'(e.src));
            chk("sb_dat", dat, e.dat);
            chk("sb_resp", 32'(resp), 32'(e.resp));
            chk("sb_last", 32'(last), 32'(e.last));
        end
    endtask

    int ifu_last_cyc = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifu_rvalid && ifu_rready) begin
                sb_pop(0, ifu_rdata, ifu_rresp, ifu_rlast);
                if (ifu_rlast) ifu_last_cyc = cyc;
            end
            if (lsu_rvalid && lsu_rready) sb_pop(1, lsu_rdata, lsu_rresp, 1'b1);
            if (lsu_bvalid && lsu_bready) sb_pop(2, 32'd0, lsu_bresp, 1'b1);
        end
    end

    // Downstream memory model: read data = address + beat index; mute suppresses R.
    logic        mute = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] ar_addr_log = '0;
    logic [7:0]  ar_len_log = '0;
    logic [1:0]  ar_burst_log = '0;
    int          ar_cyc = 0;
    logic [31:0] w_addr_log = '0, w_data_log = '0;
    logic [3:0]  w_strb_log = '0;

    initial begin
        arready = 1'b1; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = '0;
        forever begin
            @(negedge clk);
            if (rst_n && arvalid && arready) begin
                ar_addr_log  = araddr;
                ar_len_log   = arlen;
                ar_burst_log = arburst;
                ar_cyc       = cyc;
                if (!mute) begin
                    for (int b = 0; b <= int'(ar_len_log); b++) begin
                        int n;
                        @(posedge clk); #1;
                        rvalid = 1'b1; rdata = ar_addr_log + 32'(b); rlast = (b == int'(ar_len_log));
                        n = 0;
                        do begin @(negedge clk); n++; end while (!rready && n < 100);
                        if (n >= 100) chk("slv_rready_wait", 32'd0, 32'd1);
                    end
                    @(posedge clk); #1;
                    rvalid = 1'b0; rlast = 1'b0;
                end
            end
        end
    end

    initial begin
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = '0;
        forever begin
            @(negedge clk);
            if (rst_n && awvalid && wvalid) begin
                int n;
                w_addr_log = awaddr; w_data_log = wdata; w_strb_log = wstrb;
                @(posedge clk); #1;
                bvalid = 1'b1; bresp = bresp_cfg;
                n = 0;
                do begin @(negedge clk); n++; end while (!bready && n < 100);
                if (n >= 100) chk("slv_bready_wait", 32'd0, 32'd1);
                @(posedge clk); #1;
                bvalid = 1'b0;
            end
        end
    end

    // Upstream drivers: each returns at posedge+1 of the cycle after its final handshake.
    task automatic ifu_rd(input logic [31:0] a, input logic [7:0] len);
        int n;
        ifu_araddr = a; ifu_arlen = len; ifu_arsize = 3'd2; ifu_arburst = 2'b01; ifu_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ifu_arready && n < 200);
        if (n >= 200) chk("ifu_ar_wait", 32'd0, 32'd1);
        @(posedge clk); #1 ifu_arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(ifu_rvalid && ifu_rlast) && n < 200);
        if (n >= 200) chk("ifu_r_wait", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic lsu_rd(input logic [31:0] a);
        int n;
        lsu_araddr = a; lsu_arsize = 3'd2; lsu_arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!lsu_arready && n < 200);
        if (n >= 200) chk("lsu_ar_wait", 32'd0, 32'd1);
        @(posedge clk); #1 lsu_arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!lsu_rvalid && n < 200);
        if (n >= 200) chk("lsu_r_wait", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic lsu_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        lsu_awaddr = a; lsu_wdata = d; lsu_wstrb = s; lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(lsu_awready && lsu_wready) && n < 200);
        if (n >= 200) chk("lsu_aw_wait", 32'd0, 32'd1);
        @(posedge clk); #1 lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!lsu_bvalid && n < 200);
        if (n >= 200) chk("lsu_b_wait", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        ifu_araddr = '0; ifu_arsize = '0; ifu_arlen = '0; ifu_arburst = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
        lsu_araddr = '0; lsu_arsize = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
        lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0; lsu_bready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_timeout", 32'(bus_timeout), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Tie straight after reset: IFU first, LSU granted two cycles after IFU's last beat.
        push_ifu(32'h3000_0000, 8'd3);
        push_lsu_r(32'h0f00_0000);
        fork
            ifu_rd(32'h3000_0000, 8'd3);
            lsu_rd(32'h0f00_0000);
        join
        chk("tie_lsu_gap", 32'(ar_cyc - ifu_last_cyc), 32'd2);
        chk("tie_lsu_arlen", 32'(ar_len_log), 32'd0);
        chk("tie_lsu_arburst", 32'(ar_burst_log), 32'd1);

        // IFU alone: downstream arvalid low in the request cycle, high in the next.
        push_ifu(32'h3000_0000, 8'd3);
        fork
            ifu_rd(32'h3000_0000, 8'd3);
            begin
                @(negedge clk) chk("lat_req_cycle", 32'(arvalid), 32'd0);
                @(negedge clk) chk("lat_next_cycle", 32'(arvalid), 32'd1);
                chk("lat_araddr", araddr, 32'h3000_0000);
                chk("lat_arlen", 32'(arlen), 32'd3);
            end
        join
        @(negedge clk) chk("ifu_back_idle", 32'(rready), 32'd0);
        @(posedge clk); #1;

        // LSU write and read together: write first.
        push_lsu_b(2'b00);
        push_lsu_r(32'h0f00_0020);
        fork
            lsu_wr(32'h1000_0000, 32'h41, 4'b0001);
            lsu_rd(32'h0f00_0020);
        join
        chk("wr_awaddr", w_addr_log, 32'h1000_0000);
        chk("wr_wdata", w_data_log, 32'h41);
        chk("wr_wstrb", 32'(w_strb_log), 32'h1);

        // Both masters contending continuously: strict alternation starting with IFU.
        for (int i = 0; i < 3; i++) begin
            push_ifu(32'h3000_0100 + 32'(i * 16), 8'd1);
            push_lsu_r(32'h0f00_0100 + 32'(i * 16));
        end
        fork
            for (int i = 0; i < 3; i++) ifu_rd(32'h3000_0100 + 32'(i * 16), 8'd1);
            for (int j = 0; j < 3; j++) lsu_rd(32'h0f00_0100 + 32'(j * 16));
        join

        // Error write response forwarded unchanged, then back to IDLE.
        bresp_cfg = 2'b10;
        push_lsu_b(2'b10);
        lsu_wr(32'h1000_0004, 32'h55, 4'b1111);
        @(negedge clk) chk("err_back_idle", 32'(bready), 32'd0);
        bresp_cfg = 2'b00;
        chk("no_timeout_yet", 32'(bus_timeout), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Watchdog: downstream never answers; flag sets after 16 grant cycles.
        mute = 1'b1;
        @(posedge clk); #1;
        ifu_araddr = 32'h3000_0040; ifu_arlen = 8'd0; ifu_arvalid = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 ifu_arvalid = 1'b0;
        repeat (14) @(posedge clk);
        #1 chk("to_before", 32'(bus_timeout), 32'd0);
        @(posedge clk);
        #1 chk("to_set", 32'(bus_timeout), 32'd1);
        chk("to_still_granted", 32'(rready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rready", 32'(rready), 32'd0);
        chk("arst_timeout", 32'(bus_timeout), 32'd0);
        chk("arst_ifu_arready", 32'(ifu_arready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_25040129_arbiter.md
# ysyx_25040129_arbiter

Two-master AXI4 arbiter between the instruction fetch unit (IFU, read-only, burst-capable) and the load/store unit (LSU, single-beat read/write). It produces the single AXI master port that drives the crossbar, so exactly one transaction is outstanding at a time. It holds one grant from request acceptance until the final response handshake and alternates priority between masters on contention.

## Interface
Parameters:
- TIMEOUT, 4096: cycles a granted transaction may remain open before `bus_timeout` sets.
- TO_W, 13: width of the watchdog counter; must satisfy 2^TO_W > TIMEOUT.

Ports. Clock/reset are fixed: one clock; reset is asynchronous, active-low.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ifu_araddr in 32, ifu_arsize in 3, ifu_arlen in 8, ifu_arburst in 2, ifu_arvalid in 1, ifu_arready out 1: IFU read address.
- ifu_rdata out 32, ifu_rresp out 2, ifu_rvalid out 1, ifu_rlast out 1, ifu_rready in 1: IFU read data.
- lsu_araddr in 32, lsu_arsize in 3, lsu_arvalid in 1, lsu_arready out 1: LSU read address, always single beat.
- lsu_rdata out 32, lsu_rresp out 2, lsu_rvalid out 1, lsu_rready in 1: LSU read data.
- lsu_awaddr in 32, lsu_awvalid in 1, lsu_awready out 1, lsu_wdata in 32, lsu_wstrb in 4, lsu_wvalid in 1, lsu_wready out 1: LSU write address and data.
- lsu_bresp out 2, lsu_bvalid out 1, lsu_bready in 1: LSU write response.
- araddr/arsize/arlen/arburst/arvalid out, arready in; rdata/rresp/rvalid/rlast in, rready out; awaddr/awvalid out, awready in; wdata/wstrb/wvalid out, wready in; bresp/bvalid in, bready out: downstream master port to the crossbar, with the same widths as above.
- bus_timeout  out  1  sticky flag: a transaction exceeded TIMEOUT cycles.

## Operation
- States: IDLE, IFU_RD, LSU_RD, LSU_WR. `last_grant` (1 bit, 0=IFU, 1=LSU) records the master of the most recent grant.
- Requests sampled in IDLE:
  - ifu_req = ifu_arvalid.
  - lsu_wreq = lsu_awvalid && lsu_wvalid.
  - lsu_rreq = lsu_arvalid.
- LSU internal priority: if lsu_wreq and lsu_rreq are both set, the write wins (LSU_WR).
- Contention between IFU and LSU: the master that is not `last_grant` wins. Uncontended requests win immediately. `last_grant` updates on every IDLE→grant transition.
- IDLE: all downstream valids/readies, all upstream readies/valids, and all data outputs are 0.
- IFU_RD: IFU AR/R channels pass combinationally to the downstream port. rlast passes through. LSU sees all-zero outputs.
- LSU_RD: LSU AR/R channels pass through. Downstream arlen=0, arburst=2'b01 (INCR). lsu_rvalid returns to IDLE on the first beat. The downstream rlast must be 1 on that beat.
- LSU_WR: LSU AW/W/B channels pass through. Downstream AR channel is 0.
- Exit conditions:
  - IFU_RD exits on rvalid && rready && rlast.
  - LSU_RD exits on rvalid && rready.
  - LSU_WR exits on bvalid && bready.
  - Every exit goes to IDLE.
- Non-OKAY rresp/bresp are forwarded unchanged. The arbiter does not retry.
- Watchdog:
  - The counter clears in IDLE and increments each cycle in a grant state, saturating at TIMEOUT.
  - On reaching TIMEOUT, bus_timeout sets. It clears only on reset.
  - The transaction is not aborted.

## Timing
- Reset (async assert): state=IDLE, last_grant=1 (so IFU wins the first tie), counter=0, bus_timeout=0. All outputs are 0 immediately, combinationally from state.
- Reset release is synchronous to clk. The first grant is possible on the first rising edge after deassertion.
- Grant latency: a request is visible in IDLE at cycle N. The grant state is entered at edge N+1. The downstream valid is asserted in cycle N+1. Upstream ready mirrors downstream ready in the same cycle.
- Turnaround: after the final handshake at cycle M, state is IDLE in cycle M+1. The next grant is visible at M+2. Back-to-back transactions therefore cost 1 bubble cycle.
- Upstream valids must stay stable until their handshake. The arbiter adds no buffering.
- Reset asserted mid-transaction: abort to IDLE. The downstream port drops valids immediately, with no completion sent upstream.
- A request arriving in the same cycle as a final handshake is not granted until IDLE (M+1).

## Test plan
- IFU alone: arvalid, araddr=0x3000_0000, arlen=3. Downstream returns 4 beats, rlast on beat 4 → ifu_rvalid×4 with data passed through, then state returns to IDLE, with downstream arvalid first asserted 1 cycle after the request.
- Tie after reset: IFU read at 0x3000_0000 and LSU read at 0x0f00_0000 in the same cycle → IFU granted first. LSU is granted at M+2 after the IFU rlast, with downstream arlen=0.
- Alternation: both masters requesting continuously for 6 transactions → grant order IFU, LSU, IFU, LSU, IFU, LSU.
- LSU read+write together: awaddr=0x1000_0000, wdata=0x41, wstrb=4'b0001, with arvalid also high → write issued first, bresp=OKAY returned on lsu_b. The read follows on the next grant.
- Error response: downstream bresp=2'b10 → lsu_bresp=2'b10 forwarded, arbiter returns to IDLE.
- Timeout/reset: with TIMEOUT=16, downstream never asserts rvalid → bus_timeout=1 at cycle 16 of the grant. Asserting rst_n=0 then forces all outputs to 0 without a clock edge and clears bus_timeout.
